// File: rtl/poly1305_seq.sv
// Poly1305 sequencer: clamps r, pads message chunks, drives an external processblock
// unit per chunk, then fully reduces the accumulator and adds s to form the tag.
module poly1305_seq #(
  parameter int PB_TIMEOUT = 1024,
  parameter int CNT_W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_r,
  input  logic [127:0] key_s,
  output logic         key_ready,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_len,
  input  logic         blk_last,
  output logic         blk_ready,
  output logic [127:0] pb_r,
  output logic [128:0] pb_m,
  output logic [129:0] pb_a_in,
  output logic         pb_start,
  input  logic [129:0] pb_a_out,
  input  logic         pb_done,
  output logic [127:0] tag,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_ISSUE, S_WAIT_PB, S_FINAL, S_ADD, S_OUT
  } state_t;

  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [129:0] P     = {{127{1'b1}}, 3'b011};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(PB_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [129:0]      acc_q, acc_d;
  logic [127:0]      r_q, r_d, s_q, s_d, tag_q, tag_d;
  logic [128:0]      m_q, m_d;
  logic              last_q, last_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Keep the first len bytes and place the 0x01 pad byte directly above them.
  function automatic logic [128:0] pad_block(input logic [127:0] data, input logic [4:0] len);
    logic [128:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(len)) m[8*i +: 8] = data[8*i +: 8];
    end
    m[8*int'(len)] = 1'b1;
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    r_d     = r_q;
    s_d     = s_q;
    m_d     = m_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          r_d     = key_r & CLAMP;
          s_d     = key_s;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        if (blk_valid) begin
          if (blk_len > 5'd16) err_d = 1'b1;
          if (blk_len == 5'd0) begin
            if (blk_last) state_d = S_FINAL;
            else          err_d   = 1'b1;
          end else begin
            m_d     = pad_block(blk_data, (blk_len > 5'd16) ? 5'd16 : blk_len);
            last_d  = blk_last;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_PB;
      end
      S_WAIT_PB: begin
        if (pb_done) begin
          acc_d   = pb_a_out;
          state_d = last_q ? S_FINAL : S_WAIT_BLK;
        end else if (cnt_q == CNT_LIM) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINAL: begin
        // processblock may return a partially reduced value; one subtraction suffices.
        if (acc_q >= P) acc_d = acc_q - P;
        state_d = S_ADD;
      end
      S_ADD: begin
        tag_d   = acc_q[127:0] + s_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (tag_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      r_q     <= '0;
      s_q     <= '0;
      m_q     <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      s_q     <= s_d;
      m_q     <= m_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign key_ready = (state_q == S_IDLE);
  assign blk_ready = (state_q == S_WAIT_BLK);
  assign pb_start  = (state_q == S_ISSUE);
  assign tag_valid = (state_q == S_OUT);
  assign pb_r      = r_q;
  assign pb_m      = m_q;
  assign pb_a_in   = acc_q;
  assign tag       = tag_q;
  assign err       = err_q;

endmodule

// File: doc/poly1305_seq.md
Name: poly1305_seq

Overview:
- Top-level Poly1305 sequencer for the MAC engine.
- Accepts a 256-bit one-time key and a stream of up-to-16-byte message chunks.
- Clamps r, pads each chunk into a 129-bit block, and issues one processblock operation per chunk, carrying the 130-bit accumulator between operations.
- On the last chunk it fully reduces mod p = 2^130-5, adds s, and presents the 128-bit tag through a valid/ready handshake.

Parameters:
- PB_TIMEOUT, 1024: maximum cycles to wait for pb_done after pb_start before flagging an error.
- CNT_W, 11: width of the timeout counter; must hold PB_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- key_valid  in  1  key_r/key_s valid; accepted only in IDLE
- key_r  in  128  r half of key, byte 0 in [7:0]
- key_s  in  128  s half of key, byte 0 in [7:0]
- key_ready  out  1  high in IDLE
- blk_valid  in  1  message chunk valid
- blk_data  in  128  chunk bytes, byte 0 in [7:0]
- blk_len  in  5  byte count, 0..16
- blk_last  in  1  final chunk of message
- blk_ready  out  1  high in WAIT_BLK
- pb_r  out  128  clamped r to processblock
- pb_m  out  129  padded block to processblock
- pb_a_in  out  130  accumulator to processblock
- pb_start  out  1  one-cycle start pulse
- pb_a_out  in  130  processblock result
- pb_done  in  1  processblock result valid (single-cycle pulse)
- tag  out  128  final tag
- tag_valid  out  1  tag valid; held until tag_ready
- tag_ready  in  1  consumer accepts tag
- err  out  1  sticky timeout / protocol error; cleared by rst or next key accept

Behaviour:

Reset values (rst high at a clk edge):
- State IDLE.
- acc=0, r_q=0, s_q=0, pb_m=0, timeout counter=0.
- pb_start=0, tag_valid=0, tag=0, err=0.
- key_ready=1, blk_ready=0.
- Reset mid-operation abandons the message immediately; a pb_done arriving later is ignored.

States:
- IDLE:
  - On key_valid: r_q = key_r & 0x0ffffffc0ffffffc0ffffffc0fffffff; s_q = key_s; acc = 0; err = 0.
  - Next state WAIT_BLK.
- WAIT_BLK: blk_ready=1. On blk_valid, the chunk is accepted that cycle.
  - blk_len=0 with blk_last=1 (empty message or exact-multiple tail): no block issued; go to FINAL.
  - blk_len=0 with blk_last=0: err=1, chunk dropped, stay in WAIT_BLK.
  - blk_len>16: err=1, treated as 16.
  - Otherwise latch pb_m and go to ISSUE.
- Padding:
  - Bytes at index >= blk_len are zeroed.
  - Bit 8*blk_len is set.
  - For blk_len=16, pb_m[128]=1.
  - pb_m upper bits above the pad bit are 0.
- ISSUE: pb_start=1 for exactly this cycle; pb_a_in=acc and pb_r=r_q are stable from ISSUE until pb_done. Clear the counter; go to WAIT_PB.
- WAIT_PB:
  - On pb_done: acc = pb_a_out; then WAIT_BLK, or FINAL if the latched last flag is set.
  - The counter increments each cycle. At PB_TIMEOUT: err=1, go to IDLE (message aborted, no tag).
- FINAL (1 cycle): if acc >= 2^130-5 then acc = acc - (2^130-5). Go to ADD.
- ADD (1 cycle): tag = (acc[127:0] + s_q) mod 2^128. tag_valid=1. Go to OUT.
- OUT: hold tag and tag_valid until tag_valid && tag_ready; then tag_valid=0 and go to IDLE.
  - Same-cycle key_valid is not accepted; it is accepted on the next IDLE cycle.

Other rules:
- pb_done outside WAIT_PB is ignored.
- Latency per full chunk: accept -> ISSUE +1 cycle; processblock time; +1 cycle back to WAIT_BLK.
- Tag appears 2 cycles after the last pb_done (FINAL, ADD).
- All arithmetic is unsigned.
- The FINAL compare uses 130-bit acc; the subtraction result fits in 130 bits.

Test Plan:
- RFC 8439 §2.5.2 vector: key r=85:d6:be:78:57:55:6d:33:7f:44:52:fe:42:d5:06:a8, s=01:03:80:8a:fb:0d:b2:fd:4a:bf:f6:af:41:49:f5:1b; message "Cryptographic Forum Research Group" as chunks of 16,16,2 (last) -> pb_r=0x0806d5400e52447c036d555408bed685, three pb_start pulses, tag bytes a8:06:1d:c1:30:51:36:c6:c2:2b:8b:af:0c:01:27:a9.
- Empty message: key r=any, s=0x1122..ff; single chunk blk_len=0, blk_last=1 -> zero pb_start pulses, tag=s.
- Padding: r=1 (clamped stays 1), s=0, one chunk blk_len=3, data=0xFFFF..FF, last -> pb_m=0x0000_0000_01FF_FFFF (upper bits 0), tag=0x01FFFFFF.
- Full-block boundary: r=1, s=1, one 16-byte chunk of 0xFF, last -> pb_m=2^129-1, tag=(2^128-1+1) mod 2^128=0.
- Backpressure: hold tag_ready=0 for 10 cycles after tag_valid -> tag stable, key_ready=0, blk_ready=0; assert tag_ready -> tag_valid drops next cycle, IDLE.
- Timeout/reset: never return pb_done -> err=1 after PB_TIMEOUT cycles, state IDLE. Separately, assert rst during WAIT_PB, then pulse pb_done -> acc unchanged at 0, no tag_valid.
